instruction_fetch_unit: RTL

Fetch stage that sits upstream of the decoder (ControlUnit, register bank and sign-extend), taking the place of the bare pc/adder/InstructionMemory path. It holds the fetch PC and issues in-order word requests to a variable-latency instruction memory. Returned instructions are buffered with their PCs in a small prefetch queue. A valid/ready handshake presents them to decode, and a branch redirect flushes the queue and discards stale responses still in flight.

---
 rtl/ifu_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 101 ++++++++++
 rtl/instruction_fetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ifu_state_e : fetch control states
//   INST_BYTES  : PC increment between sequential fetches
//   slot_t      : one prefetch queue entry (pc, instruction, valid)
package ifu_pkg;

   typedef enum logic [1:0] {
      S_RESET,
      S_RUN,
      S_DRAIN
   } ifu_state_e;

   localparam int unsigned INST_BYTES     = 4;
   localparam int unsigned IFU_ADDR_WIDTH = 64;
   localparam int unsigned IFU_INST_WIDTH = 32;

   // Field widths are the widest supported; narrower instances size-cast on access.
   typedef struct packed {
      logic [IFU_ADDR_WIDTH-1:0] pc;
      logic [IFU_INST_WIDTH-1:0] inst;
      logic                      valid;
   } slot_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: DEPTH slots addressed by three wrapping pointers.
//   alloc : next slot to reserve when a request is accepted
//   fill  : oldest reserved slot still waiting for its memory response
//   head  : oldest filled slot, presented to decode
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   flush_i             discard everything; all pointers collapse onto alloc
//   alloc_i, alloc_pc_i reserve a slot for an accepted request
//   fill_i, fill_data_i write a returned instruction into the fill slot
//   pop_i               decode consumed the head entry
//   full_o              alloc - head == DEPTH
//   fill_empty_o        no reserved slot awaits a response
//   pending_o           requests in flight (alloc - fill)
//   head_valid_o, head_inst_o, head_pc_o   head entry towards decode
module fetch_queue
   import ifu_pkg::*;
#(
   parameter  int unsigned ADDR_WIDTH = IFU_ADDR_WIDTH,
   parameter  int unsigned INST_WIDTH = IFU_INST_WIDTH,
   parameter  int unsigned DEPTH      = 4,
   localparam int unsigned PW         = $clog2(DEPTH) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  alloc_i,
   input  logic [ADDR_WIDTH-1:0] alloc_pc_i,
   input  logic                  fill_i,
   input  logic [INST_WIDTH-1:0] fill_data_i,
   input  logic                  pop_i,
   output logic                  full_o,
   output logic                  fill_empty_o,
   output logic [PW-1:0]         pending_o,
   output logic                  head_valid_o,
   output logic [INST_WIDTH-1:0] head_inst_o,
   output logic [ADDR_WIDTH-1:0] head_pc_o
);

   slot_t         slots_q [DEPTH];
   logic [PW-1:0] alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
   logic [PW-2:0] alloc_idx, fill_idx, head_idx;
   logic          do_alloc, do_fill, do_pop;

   assign alloc_idx = alloc_q[PW-2:0];
   assign fill_idx  = fill_q[PW-2:0];
   assign head_idx  = head_q[PW-2:0];

   assign full_o       = ((alloc_q - head_q) == PW'(DEPTH));
   assign fill_empty_o = (fill_q == alloc_q);
   assign pending_o    = alloc_q - fill_q;

   assign head_valid_o = slots_q[head_idx].valid && (head_q != fill_q);
   assign head_inst_o  = INST_WIDTH'(slots_q[head_idx].inst);
   assign head_pc_o    = ADDR_WIDTH'(slots_q[head_idx].pc);

   assign do_alloc = alloc_i && !full_o;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign do_fill  = fill_i && !fill_empty_o;
   assign do_pop   = pop_i && head_valid_o;

   always_comb begin
      alloc_d = alloc_q;
      fill_d  = fill_q;
      head_d  = head_q;
      if (flush_i) begin
         fill_d = alloc_q;
         head_d = alloc_q;
      end else begin
         if (do_alloc) alloc_d = alloc_q + PW'(1);
         if (do_fill)  fill_d  = fill_q + PW'(1);
         if (do_pop)   head_d  = head_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         alloc_q <= '0;
         fill_q  <= '0;
         head_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) slots_q[i] <= '0;
      end else begin
         alloc_q <= alloc_d;
         fill_q  <= fill_d;
         head_q  <= head_d;
         if (flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) slots_q[i].valid <= 1'b0;
         end else begin
            // alloc and fill never target the same slot: that needs empty or full.
            if (do_alloc) begin
               slots_q[alloc_idx].pc    <= IFU_ADDR_WIDTH'(alloc_pc_i);
               slots_q[alloc_idx].valid <= 1'b0;
            end
            if (do_fill) begin
               slots_q[fill_idx].inst  <= IFU_INST_WIDTH'(fill_data_i);
               slots_q[fill_idx].valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the fetch PC, issues in-order word requests to a
// variable-latency instruction memory, buffers returned instructions with
// their PCs and hands them to decode over valid/ready. A redirect flushes
// the buffer; responses to requests issued before it are counted and dropped.
// Ports:
//   clk, reset (sync, active low)
//   imem_req_valid/ready/addr    request channel to instruction memory
//   imem_resp_valid/data         in-order responses
//   redirect_valid/pc            taken branch/jump target
//   inst_valid/ready/data/pc     head instruction towards decode
module instruction_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned          ADDR_WIDTH = 64,
   parameter int unsigned          INST_WIDTH = 32,
   parameter int unsigned          DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [INST_WIDTH-1:0] imem_resp_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [INST_WIDTH-1:0] inst_data,
   output logic [ADDR_WIDTH-1:0] inst_pc
);

   localparam int unsigned PW = $clog2(DEPTH) + 1;

   ifu_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]         drop_cnt_q, drop_cnt_d;
   logic [PW-1:0]         pending;
   logic                  q_full, q_fill_empty;
   logic                  redir, accept, resp_consume, resp_fill;

   assign redir          = redirect_valid && (state_q != S_RESET);
   assign imem_req_valid = (state_q == S_RUN) && !q_full && !redirect_valid;
   assign imem_req_addr  = fetch_pc_q;
   assign accept         = imem_req_valid && imem_req_ready;
   assign resp_fill      = imem_resp_valid && (drop_cnt_q == '0);
   // A response retires either a drop or a pending slot; a stray one retires nothing.
   assign resp_consume   = imem_resp_valid && ((drop_cnt_q != '0) || !q_fill_empty);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      drop_cnt_d = drop_cnt_q;
      if (redir) begin
         fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         // Everything still in flight becomes stale, less a response landing now.
         drop_cnt_d = drop_cnt_q + pending - PW'(resp_consume);
      end else begin
         if (accept) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INST_BYTES);
         if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - PW'(1);
      end
      unique case (state_q)
         S_RESET:        state_d = S_RUN;
         S_RUN, S_DRAIN: state_d = (drop_cnt_d != '0) ? S_DRAIN : S_RUN;
         default:        state_d = S_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_RESET;
         fetch_pc_q <= RESET_PC;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   fetch_queue #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INST_WIDTH (INST_WIDTH),
      .DEPTH      (DEPTH)
   ) u_queue (
      .clk_i        (clk),
      .rst_ni       (reset),
      .flush_i      (redir),
      .alloc_i      (accept),
      .alloc_pc_i   (fetch_pc_q),
      .fill_i       (resp_fill),
      .fill_data_i  (imem_resp_data),
      .pop_i        (inst_ready),
      .full_o       (q_full),
      .fill_empty_o (q_fill_empty),
      .pending_o    (pending),
      .head_valid_o (inst_valid),
      .head_inst_o  (inst_data),
      .head_pc_o    (inst_pc)
   );

endmodule
